cla_select_pipe_adder: RTL and testbench
========================================

# cla_select_pipe_adder

Parametrised, two-stage pipelined hybrid carry-lookahead / carry-select adder-subtractor with a valid/ready handshake. Stage 1 forms per-block generate/propagate and both conditional block sums (carry-in 0 and 1). Stage 2 resolves the block carries by lookahead and selects the final sum. It is the general-width, registered successor of the fixed 12-bit combinational lookahead carry unit, for use inside datapaths that need a sustained one-result-per-cycle adder.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, carry-select block width in bits; 2..8.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/controls present
- in_ready  output  1  block accepts this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add mode only)
- sub  input  1  1 = A − B (B inverted, carry-in forced to 1, ci ignored)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts
- sum  output  WIDTH  result
- co  output  1  carry-out of MSB (in sub mode, 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
- Effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : ci.
- Stage 1 registers, per block k (NB = WIDTH/BLOCK blocks):
  - block generate G[k] and propagate P[k], computed from the per-bit g = a&bb and p = a^bb;
  - conditional sums S0[k] and S1[k];
  - conditional block carry-outs C0[k] and C1[k];
  - c0;
  - the bit-(WIDTH−1) a and bb values, for overflow.
- Stage 2 combinational logic:
  - block carry-in cin[0] = c0;
  - cin[k+1] = G[k] | (P[k] & cin[k]), flattened into two-level lookahead (no ripple chain);
  - block k sum = cin[k] ? S1[k] : S0[k];
  - co = cin[NB];
  - ovf = (aMSB == bbMSB) && (sum[MSB] != aMSB).
- Arithmetic is modulo 2^WIDTH. No saturation.
- Stage 2 contents are held stable while out_valid && !out_ready.
- Per-stage valid bits v1 and v2:
  - adv2 = !v2 || out_ready;
  - adv1 = !v1 || adv2;
  - in_ready = adv1 (combinational, no dependency on in_valid).
- Stage register update rules:
  - stage 1 loads when adv1 (v1 <= in_valid);
  - stage 2 loads when adv2 (v2 <= v1).
- out_valid = v2. sum, co and ovf are driven from stage-2 registers plus select logic only.
- Elaboration check: WIDTH % BLOCK != 0 or BLOCK outside 2..8 → $error.

## Timing
- Latency: 2 cycles from input transfer to out_valid. Throughput 1/cycle while out_ready = 1.
- Reset (async assert, sync-released by the surrounding system): v1 = v2 = 0, all data registers 0.
- Outputs at reset: out_valid = 0, sum = 0, co = 0, ovf = 0, in_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0. The two held results are not lost or overwritten.
- Simultaneous output transfer and input transfer when full: accepted. Occupancy stays 2 and there is no bubble.
- out_ready deasserted for N cycles, then reasserted: results emerge in input order with no duplicates.
- Reset asserted mid-stream: in-flight results are discarded immediately. The first post-reset output comes from the first post-reset input.
- in_valid = 0: bubbles propagate. Data in a bubble stage is don't-care but must not raise out_valid.

## Structure
- Shared package adder_pkg:
  - default WIDTH and BLOCK constants;
  - a packed struct for the stage-1 register slice per block (G, P, S0, S1, C0, C1);
  - function nblocks(WIDTH, BLOCK).
- One sub-module, block_gp_select:
  - BLOCK-bit combinational slice producing G, P, S0, S1, C0, C1;
  - instantiated NB times via generate.
- Top level holds the lookahead carry network, sum select, overflow logic and pipeline/handshake registers.

## Test plan
All scenarios use WIDTH = 16, BLOCK = 4 unless noted.
- 0xFFFF + 0x0001, ci = 0, sub = 0 → sum 0x0000, co 1, ovf 0, two cycles after accept. Exercises the full carry propagate across all blocks.
- 0x7FFF + 0x0001 → sum 0x8000, co 0, ovf 1. Then 0x1234 + 0x4321 with ci = 1 → sum 0x5556, co 0, ovf 0.
- Subtraction:
  - sub = 1, 0x0005 − 0x0007 → sum 0xFFFE, co 0, ovf 0;
  - sub = 1, 0x8000 − 0x0001 → sum 0x7FFF, co 1, ovf 1.
- Streaming under backpressure:
  - stream 10 random vectors with in_valid held high;
  - hold out_ready = 0 for 3 cycles mid-stream → in_ready drops after 2 held results;
  - all 10 results match the golden model, in order, with no loss.
- Reset mid-stream: assert rst with 2 results in flight → out_valid drops immediately and all outputs read 0. The next accepted 0x0001 + 0x0001 yields 0x0002.
- WIDTH = 32, BLOCK = 8: 10k random add/sub vectors with random in_valid/out_ready against a reference model. Includes 0xFFFFFFFF + 0 with ci = 1 → sum 0x00000000, co 1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the pipelined carry-lookahead / carry-select adder.
package adder_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefBlock = 4;
  localparam int unsigned MaxBlock = 8;

  // Per-block stage-1 slice; sum fields sized for the widest legal block.
  typedef struct packed {
    logic                g;
    logic                p;
    logic [MaxBlock-1:0] s0;
    logic [MaxBlock-1:0] s1;
    logic                c0;
    logic                c1;
  } blk_slice_t;

  function automatic int nblocks(input int unsigned width, input int unsigned block);
    return int'(width / block);
  endfunction

endpackage

// File: rtl/block_gp_select.sv
// One carry-select block: group generate/propagate plus both conditional sums and carries.
module block_gp_select
  import adder_pkg::*;
#(
  parameter int unsigned BLOCK = DefBlock
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] bb,
  output blk_slice_t       slice
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic             c_zero;
  logic             c_one;

  assign g = a & bb;
  assign p = a ^ bb;

  always_comb begin
    slice  = '0;
    c_zero = 1'b0;
    c_one  = 1'b1;
    for (int i = 0; i < int'(BLOCK); i++) begin
      slice.s0[i] = p[i] ^ c_zero;
      slice.s1[i] = p[i] ^ c_one;
      c_zero      = g[i] | (p[i] & c_zero);
      c_one       = g[i] | (p[i] & c_one);
    end
    // Carry-out with carry-in 0 is exactly the group generate.
    slice.g  = c_zero;
    slice.p  = &p;
    slice.c0 = c_zero;
    slice.c1 = c_one;
  end

endmodule

// File: rtl/cla_select_pipe_adder.sv
// Two-stage adder-subtractor: stage 1 registers block G/P and conditional sums,
// stage 2 resolves block carries by two-level lookahead and selects the sum.
module cla_select_pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned BLOCK = DefBlock
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NB = nblocks(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > MaxBlock) begin : g_param_check
    $error("cla_select_pipe_adder: WIDTH must be a multiple of BLOCK, BLOCK in 2..8");
  end

  logic [WIDTH-1:0] bb;
  logic             c0;
  blk_slice_t       slice_d [NB];

  assign bb = sub ? ~b : b;
  assign c0 = sub | ci;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    block_gp_select #(
      .BLOCK(BLOCK)
    ) u_blk (
      .a    (a[k*BLOCK +: BLOCK]),
      .bb   (bb[k*BLOCK +: BLOCK]),
      .slice(slice_d[k])
    );
  end

  logic       v1_q, v2_q;
  logic       adv1, adv2;
  blk_slice_t s1_q [NB];
  blk_slice_t s2_q [NB];
  logic       c0_1q, amsb_1q, bbmsb_1q;
  logic       c0_2q, amsb_2q, bbmsb_2q;

  assign adv2      = !v2_q || out_ready;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      c0_1q    <= 1'b0;
      amsb_1q  <= 1'b0;
      bbmsb_1q <= 1'b0;
      c0_2q    <= 1'b0;
      amsb_2q  <= 1'b0;
      bbmsb_2q <= 1'b0;
      for (int k = 0; k < NB; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
    end else begin
      if (adv1) begin
        v1_q     <= in_valid;
        c0_1q    <= c0;
        amsb_1q  <= a[WIDTH-1];
        bbmsb_1q <= bb[WIDTH-1];
        for (int k = 0; k < NB; k++) s1_q[k] <= slice_d[k];
      end
      if (adv2) begin
        v2_q     <= v1_q;
        c0_2q    <= c0_1q;
        amsb_2q  <= amsb_1q;
        bbmsb_2q <= bbmsb_1q;
        for (int k = 0; k < NB; k++) s2_q[k] <= s1_q[k];
      end
    end
  end

  logic [NB:0] cin;
  logic        term;
  logic        prod;

  // Each block carry is an independent sum of products over G/P and c0: no ripple.
  always_comb begin
    cin    = '0;
    term   = 1'b0;
    prod   = 1'b0;
    cin[0] = c0_2q;
    for (int k = 0; k < NB; k++) begin
      prod = c0_2q;
      for (int m = 0; m <= k; m++) prod = prod & s2_q[m].p;
      term = prod;
      for (int j = 0; j <= k; j++) begin
        prod = s2_q[j].g;
        for (int m = j + 1; m <= k; m++) prod = prod & s2_q[m].p;
        term = term | prod;
      end
      cin[k+1] = term;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NB; k++) begin
      sum[k*BLOCK +: BLOCK] = cin[k] ? s2_q[k].s1[BLOCK-1:0] : s2_q[k].s0[BLOCK-1:0];
    end
  end

  assign co  = cin[NB-1] ? s2_q[NB-1].c1 : s2_q[NB-1].c0;
  assign ovf = (amsb_2q == bbmsb_2q) && (sum[WIDTH-1] != amsb_2q);

endmodule

// File: tb/tb_cla_select_pipe_adder.sv
// Scoreboard bench: 16/4 directed, backpressure and reset cases, then 32/8 random traffic.
module tb_cla_select_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid32, in_ready32, ci32, sub32, out_valid32, out_ready32, co32, ovf32;
  logic [31:0] a32, b32, sum32;

  cla_select_pipe_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .co(co), .ovf(ovf)
  );

  cla_select_pipe_adder #(.WIDTH(32), .BLOCK(8)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .ci(ci32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32),
    .co(co32), .ovf(ovf32)
  );

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic civ, input logic subv);
    exp_t        e;
    logic [31:0] mask, bbv;
    logic [32:0] full;
    mask   = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    bbv    = (subv ? ~bv : bv) & mask;
    full   = {1'b0, av & mask} + {1'b0, bbv} + 33'(subv ? 1'b1 : civ);
    e.sum  = full[31:0] & mask;
    e.co   = (w == 32) ? full[32] : full[16];
    e.ovf  = (av[w-1] == bbv[w-1]) && (e.sum[w-1] != av[w-1]);
    e.acc_cyc = cyc;
    e.chk_lat = 1'b0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q16.size() == 0) check("spurious16", 1, 0);
        else begin
          e = q16.pop_front();
          check("sum16", sum, e.sum);
          check("co16", co, e.co);
          check("ovf16", ovf, e.ovf);
          if (e.chk_lat) check("latency16", cyc - e.acc_cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        e = model(16, {16'h0, a}, {16'h0, b}, ci, sub);
        e.chk_lat = lat_mode;
        q16.push_back(e);
      end
      if (out_valid32 && out_ready32) begin
        if (q32.size() == 0) check("spurious32", 1, 0);
        else begin
          e = q32.pop_front();
          check("sum32", sum32, e.sum);
          check("co32", co32, e.co);
          check("ovf32", ovf32, e.ovf);
        end
      end
      if (in_valid32 && in_ready32) q32.push_back(model(32, a32, b32, ci32, sub32));
    end
  end

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                        input logic subv);
    int t = 0;
    a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        check("accept_timeout16", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit wide);
    int t = 0;
    while ((wide ? q32.size() : q16.size()) != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    check(wide ? "drain32" : "drain16", wide ? q32.size() : q16.size(), 0);
  endtask

  initial begin
    logic [15:0] sa [10];
    logic [15:0] sb [10];
    int          idx, c, sent;
    bit          pending;

    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; ci = 0; sub = 0; out_ready = 0;
    in_valid32 = 0; a32 = 0; b32 = 0; ci32 = 0; sub32 = 0; out_ready32 = 0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_co", co, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send16(16'h1234, 16'h4321, 1'b1, 1'b0);
    send16(16'h0005, 16'h0007, 1'b1, 1'b1);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1);
    drain(1'b0);

    // Streaming with a backpressure window while in_valid stays high.
    lat_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    idx = 0;
    c   = 0;
    while (idx < 10 && c < 100) begin
      a = sa[idx]; b = sb[idx]; ci = sa[idx][0]; sub = 1'(idx % 2); in_valid = 1'b1;
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
      if (c == 4) begin
        check("full_in_ready", in_ready, 0);
        check("full_out_valid", out_valid, 1);
      end
      if (in_ready) idx++;
      c++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", idx, 10);
    drain(1'b0);

    // Reset with two results held in the pipeline.
    out_ready = 1'b0;
    send16(16'h0001, 16'h0002, 1'b0, 1'b0);
    send16(16'h0003, 16'h0004, 1'b0, 1'b0);
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_co", co, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_in_ready", in_ready, 1);
    q16.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    send16(16'h0001, 16'h0001, 1'b0, 1'b0);
    drain(1'b0);
    lat_mode = 1'b0;

    // Wide random traffic with random valid/ready.
    sent    = 0;
    c       = 0;
    pending = 1'b1;
    a32 = 32'hFFFF_FFFF; b32 = 32'h0; ci32 = 1'b1; sub32 = 1'b0;
    while (sent < 10000 && c < 80000) begin
      if (!pending) begin
        a32 = $urandom; b32 = $urandom;
        ci32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      in_valid32  = ($urandom_range(0, 3) != 0);
      out_ready32 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid32 && in_ready32) begin
        pending = 1'b0;
        sent++;
      end
      c++;
      @(posedge clk); #1;
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b1;
    check("sent32", sent, 10000);
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
